// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that sits directly in front of the IF/ID register.
// It owns the PC and keeps at most one instruction-memory request in flight.
// It presents the fetched word and its pc+4 to IF/ID, and holds them while the
// hazard unit stalls. Branch/jump redirects resolved in ID replace the PC.
// A wrong-path fetch that is already in flight is dropped when its data
// returns.
//
// Parameters
//   RESET_PC        PC loaded on reset. Bits [1:0] are forced to zero.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_req        request valid; high only while waiting to issue
//   imem_addr       request address; always equal to the current PC
//   imem_ready      memory accepts the request this cycle (when imem_req=1)
//   imem_rvalid     read-data valid; one pulse per accepted request
//   imem_rdata      fetched instruction word
//   stall_in        pipeline freeze; hold the delivered instruction
//   redirect_valid  one-cycle taken branch/jump pulse from ID
//   redirect_pc     new PC; bits [1:0] ignored
//   instruction     instruction to IF/ID; zero (NOP) whenever valid_out=0
//   pc_plus_4       address of the delivered instruction + 4; holds last value
//   valid_out       instruction/pc_plus_4 are valid this cycle
//
// Build option
//   FETCH_PERF_EN   when defined, adds 32-bit wrapping counters:
//                   perf_fetched   - captured responses
//                   perf_discarded - dropped (wrong-path) responses
//                   perf_stall     - S_OUT cycles held by stall_in
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_4,
  output logic        valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;

  logic [31:0] redir_pc;
  logic [31:0] pc_inc;
  logic        unused_redirect_lsb;

  // Word alignment: the low two bits of a redirect target are discarded.
  assign redir_pc            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  // Wraps modulo 2^32, so 32'hFFFF_FFFC + 4 yields 32'h0.
  assign pc_inc              = pc_q + 32'd4;

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc_plus_4   = pcp4_q;
  assign valid_out   = valid_q;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC_AL;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
    end
  end

  // ---- next-state / output logic ----
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;

    unique case (state_q)
      S_REQ: begin
        // A redirect always wins the PC. If the memory accepted the old-PC
        // request in the same cycle, its response is wrong-path and must be
        // dropped when it arrives.
        if (redirect_valid) begin
          pc_d = redir_pc;
        end
        if (imem_ready) begin
          state_d = S_WAIT;
          if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (!imem_rvalid) begin
          if (redirect_valid) begin
            pc_d   = redir_pc;
            drop_d = 1'b1;
          end
        end else if (drop_q || redirect_valid) begin
          // Wrong-path response: throw the data away and refetch.
          drop_d  = 1'b0;
          state_d = S_REQ;
          if (redirect_valid) begin
            pc_d = redir_pc;
          end
        end else begin
          instr_d = imem_rdata;
          pcp4_d  = pc_inc;
          pc_d    = pc_inc;
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        // Redirect outranks stall: the held instruction is on the wrong path.
        if (redirect_valid) begin
          valid_d = 1'b0;
          instr_d = 32'd0;
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (!stall_in) begin
          valid_d = 1'b0;
          instr_d = 32'd0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic        ev_fetch;
  logic        ev_discard;
  logic        ev_stall;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_discarded_q;
  logic [31:0] perf_stall_q;

  assign ev_fetch   = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect_valid;
  assign ev_discard = (state_q == S_WAIT) && imem_rvalid && (drop_q || redirect_valid);
  assign ev_stall   = (state_q == S_OUT) && stall_in && !redirect_valid;

  // ---- performance counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= 32'd0;
      perf_discarded_q <= 32'd0;
      perf_stall_q     <= 32'd0;
    end else begin
      if (ev_fetch) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (ev_discard) begin
        perf_discarded_q <= perf_discarded_q + 32'd1;
      end
      if (ev_stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
  assign perf_stall     = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage with RESET_PC = 32'h400. A memory responder
// answers each accepted request after a programmable latency using a fixed
// address->data table. The stimulus process pushes the expected
// {instruction, pc_plus_4} of every fetch it lets through into a queue; a
// monitor pops an entry at each new valid_out, checks held values during
// stall, and checks NOP / held pc_plus_4 whenever valid_out is low.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_plus_4;
  logic        valid_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
  logic [31:0] perf_stall;
`endif

  int          n_cmp;
  int          n_mis;
  int          lat;
  logic        mon_en;
  logic [63:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0400)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .pc_plus_4      (pc_plus_4),
    .valid_out      (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
    .perf_stall     (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0400: mem_word = 32'h2008_0005;
      32'h0000_0404: mem_word = 32'h8C09_0010;
      32'h0000_0408: mem_word = 32'h0128_5020;
      32'h0000_040C: mem_word = 32'hDEAD_BEEF;
      32'h0000_1000: mem_word = 32'h3C01_1234;
      32'h0000_1004: mem_word = 32'hAC0A_0004;
      32'h0000_0008: mem_word = 32'h1234_5678;
      32'hFFFF_FFFC: mem_word = 32'h0800_0100;
      32'h0000_0000: mem_word = 32'hCAFE_0000;
      32'h0000_0004: mem_word = 32'h5555_AAAA;
      default:       mem_word = 32'hBAD0_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Memory responder: acceptance is judged half a cycle before the edge.
  initial begin
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && imem_ready) begin
        a = imem_addr;
        @(posedge clk); #1;
        for (int k = 1; k < lat; k++) begin
          @(posedge clk); #1;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic        prev_v;
    logic [31:0] exp_i;
    logic [31:0] exp_p4;
    logic [63:0] e;
    prev_v = 1'b0;
    exp_i  = 32'd0;
    exp_p4 = 32'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!rst_n) begin
          prev_v = 1'b0;
          exp_p4 = 32'd0;
          chk("mon_reset_instr", instruction, 32'd0);
        end else if (valid_out) begin
          if (!prev_v) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_mis++;
              $display("FAIL mon_unexpected: delivered %h with pc_plus_4 %h, expected no delivery",
                       instruction, pc_plus_4);
            end else begin
              e      = exp_q.pop_front();
              exp_i  = e[63:32];
              exp_p4 = e[31:0];
              chk("mon_instr", instruction, exp_i);
              chk("mon_pc_plus_4", pc_plus_4, exp_p4);
            end
          end else begin
            chk("mon_hold_instr", instruction, exp_i);
            chk("mon_hold_pc_plus_4", pc_plus_4, exp_p4);
          end
        end else begin
          chk("mon_nop_instr", instruction, 32'd0);
          chk("mon_idle_pc_plus_4", pc_plus_4, exp_p4);
        end
        prev_v = valid_out;
      end
    end
  end

  // Issue one request: call at posedge+1 while in S_REQ; returns at
  // acceptance edge + 1.
  task automatic start_fetch();
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  // Full fetch: count valid_out cycles and cycles until the next request.
  task automatic fetch_cycle(output int vcnt, output int ncyc);
    start_fetch();
    vcnt = 0;
    ncyc = 0;
    while (!imem_req && ncyc < 20) begin
      if (valid_out) vcnt++;
      @(posedge clk); #1;
      ncyc++;
    end
  endtask

  initial begin
    int vc;
    int nc;
    int hc;
    int n;
    n_cmp          = 0;
    n_mis          = 0;
    lat            = 1;
    mon_en         = 1'b0;
    rst_n          = 1'b1;
    imem_ready     = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state (async)
    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    #1;
    chk1("rst_valid_out", valid_out, 1'b0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_pc_plus_4", pc_plus_4, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0400);
    chk1("rst_imem_req", imem_req, 1'b1);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("boot_addr", imem_addr, 32'h0000_0400);

    // First fetch, 1-cycle memory
    exp_q.push_back({32'h2008_0005, 32'h0000_0404});
    fetch_cycle(vc, nc);
    chk("f400_valid_cycles", 32'(vc), 32'd1);
    chk("f400_issue_cycles", 32'(nc), 32'd2);
    chk("f400_next_addr", imem_addr, 32'h0000_0404);

    // 3-cycle memory latency
    lat = 3;
    exp_q.push_back({32'h8C09_0010, 32'h0000_0408});
    fetch_cycle(vc, nc);
    chk("lat3_valid_cycles", 32'(vc), 32'd1);
    chk("lat3_issue_cycles", 32'(nc), 32'd4);
    chk("lat3_next_addr", imem_addr, 32'h0000_0408);

    // Stall for 4 cycles in S_OUT
    lat = 1;
    exp_q.push_back({32'h0128_5020, 32'h0000_040C});
    start_fetch();
    @(posedge clk); #1;
    hc = 0;
    if (valid_out) hc++;
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (valid_out) hc++;
      chk1("stall_imem_req", imem_req, 1'b0);
    end
    stall_in = 1'b0;
    chk("stall_hold_cycles", 32'(hc), 32'd5);
    @(posedge clk); #1;
    chk1("post_stall_valid", valid_out, 1'b0);
    chk("post_stall_addr", imem_addr, 32'h0000_040C);
`ifdef FETCH_PERF_EN
    chk("perf_stall_4", perf_stall, 32'd4);
`endif

    // Redirect during S_WAIT; in-flight 0xDEADBEEF response must be dropped
    lat = 3;
    start_fetch();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("redir_wait_addr", imem_addr, 32'h0000_1000);
    chk1("redir_wait_req", imem_req, 1'b0);
    n = 0;
    while (!imem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("redir_wait_back_req", imem_req, 1'b1);
    chk("redir_wait_next_addr", imem_addr, 32'h0000_1000);
`ifdef FETCH_PERF_EN
    chk("perf_discarded_1", perf_discarded, 32'd1);
    chk("perf_fetched_3", perf_fetched, 32'd3);
`endif

    // Fetch at redirect target
    lat = 1;
    exp_q.push_back({32'h3C01_1234, 32'h0000_1004});
    fetch_cycle(vc, nc);
    chk("f1000_valid_cycles", 32'(vc), 32'd1);
    chk("f1000_next_addr", imem_addr, 32'h0000_1004);

    // Redirect and stall together in S_OUT: redirect wins
    exp_q.push_back({32'hAC0A_0004, 32'h0000_1008});
    start_fetch();
    @(posedge clk); #1;
    chk1("out_valid_before_redir", valid_out, 1'b1);
    stall_in       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    @(posedge clk); #1;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    chk1("out_redir_valid", valid_out, 1'b0);
    chk1("out_redir_req", imem_req, 1'b1);
    chk("out_redir_addr", imem_addr, 32'h0000_0008);
`ifdef FETCH_PERF_EN
    chk("perf_stall_still_4", perf_stall, 32'd4);
`endif

    // Redirect and ready in the same S_REQ cycle
    imem_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    @(posedge clk); #1;
    imem_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("req_redir_addr", imem_addr, 32'h0000_0020);
    chk1("req_redir_wait", imem_req, 1'b0);
    @(posedge clk); #1;
    chk1("req_redir_back_req", imem_req, 1'b1);
    chk("req_redir_next_addr", imem_addr, 32'h0000_0020);
    chk1("req_redir_no_valid", valid_out, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_discarded_2", perf_discarded, 32'd2);
`endif

    // Redirect alone in S_REQ (with stall, which has no effect there)
    redirect_valid = 1'b1;
    stall_in       = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    stall_in       = 1'b0;
    chk("req_only_redir_addr", imem_addr, 32'hFFFF_FFFC);
    chk1("req_only_redir_req", imem_req, 1'b1);

    // Wrap-around fetch
    exp_q.push_back({32'h0800_0100, 32'h0000_0000});
    fetch_cycle(vc, nc);
    chk("wrap_valid_cycles", 32'(vc), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    exp_q.push_back({32'hCAFE_0000, 32'h0000_0004});
    fetch_cycle(vc, nc);
    chk("f0_next_addr", imem_addr, 32'h0000_0004);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_7", perf_fetched, 32'd7);
`endif

    // Reset mid-S_WAIT; the stale response later lands in S_REQ
    lat = 3;
    start_fetch();
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_valid", valid_out, 1'b0);
    chk("midrst_instruction", instruction, 32'd0);
    chk("midrst_pc_plus_4", pc_plus_4, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0000_0400);
    chk1("midrst_req", imem_req, 1'b1);
`ifdef FETCH_PERF_EN
    chk("midrst_perf_fetched", perf_fetched, 32'd0);
    chk("midrst_perf_discarded", perf_discarded, 32'd0);
    chk("midrst_perf_stall", perf_stall, 32'd0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk1("postrst_valid", valid_out, 1'b0);
    chk("postrst_addr", imem_addr, 32'h0000_0400);
    chk1("postrst_req", imem_req, 1'b1);

    lat = 1;
    exp_q.push_back({32'h2008_0005, 32'h0000_0404});
    fetch_cycle(vc, nc);
    chk("postrst_valid_cycles", 32'(vc), 32'd1);
    chk("postrst_next_addr", imem_addr, 32'h0000_0404);
`ifdef FETCH_PERF_EN
    chk("postrst_perf_fetched", perf_fetched, 32'd1);
`endif

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a req/ready + rvalid handshake.
- Delivers instruction and pc_plus_4 to IF/ID, and holds them under stall.
- Accepts branch/jump redirects resolved in ID, discarding any in-flight wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  request valid (combinational from state)
imem_addr  output  32  request address, equals pc
imem_ready  input  1  memory accepts request this cycle when imem_req=1
imem_rvalid  input  1  read data valid (one pulse per accepted request, at least 1 cycle after acceptance)
imem_rdata  input  32  fetched instruction
stall_in  input  1  pipeline freeze from hazard unit; hold delivered instruction
redirect_valid  input  1  taken branch/jump from ID, one-cycle pulse
redirect_pc  input  32  new PC; bits [1:0] ignored
instruction  output  32  instruction to IF/ID; 32'd0 (NOP) whenever valid_out=0
pc_plus_4  output  32  address of delivered instruction + 4; holds last value when valid_out=0
valid_out  output  1  instruction/pc_plus_4 valid this cycle

Behaviour:
- Reset (rst_n=0, async): state=S_REQ, pc=RESET_PC, drop=0, valid_out=0, instruction=0, pc_plus_4=0. Outputs leave reset values on the first clk edge after rst_n rises.
- pc[1:0] is always 0. Arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
- imem_req=1 only in S_REQ. imem_addr=pc at all times.
- S_REQ:
  - redirect_valid & imem_ready: pc<=redirect_pc, drop<=1, ->S_WAIT. The old-pc request was accepted and its response will be discarded.
  - redirect_valid only: pc<=redirect_pc, stay in S_REQ.
  - imem_ready only: ->S_WAIT.
  - Otherwise: stay.
- S_WAIT:
  - No imem_rvalid: if redirect_valid, pc<=redirect_pc and drop<=1; stay.
  - imem_rvalid & (drop | redirect_valid): discard data, drop<=0, pc<=redirect_pc if redirect_valid else unchanged, ->S_REQ.
  - imem_rvalid otherwise: instruction<=imem_rdata, pc_plus_4<=pc+4, pc<=pc+4, valid_out<=1, ->S_OUT.
- S_OUT (valid_out=1):
  - redirect_valid (priority over stall): valid_out<=0, instruction<=0, pc<=redirect_pc, ->S_REQ.
  - stall_in: hold all outputs, stay.
  - Otherwise: valid_out<=0, instruction<=0, ->S_REQ.
- Latency: data on rvalid edge N appears on outputs after edge N. Minimum issue-to-issue is 3 cycles with 1-cycle memory.
- Only one outstanding request exists; rvalid outside S_WAIT is ignored.
- redirect_valid and stall_in together in S_REQ/S_WAIT: redirect applies, stall has no effect.
- Reset asserted mid-S_WAIT: the in-flight response after reset is not expected. If it arrives while in S_REQ it is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32-bit, increments each S_WAIT->S_OUT capture), perf_discarded (32-bit, increments each dropped response) and perf_stall (32-bit, increments each S_OUT cycle with stall_in=1 and no redirect). All three are cleared by rst_n and wrap at 2^32.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h400, ready=1, rvalid 1 cycle after accept, rdata=32'h2008_0005 -> imem_addr=32'h400 in S_REQ; valid_out=1 with instruction=32'h2008_0005, pc_plus_4=32'h404; next request addr=32'h404.
- 3-cycle memory latency -> valid_out stays 0 and instruction stays 0 throughout S_WAIT; single-cycle valid_out on capture.
- stall_in=1 for 4 cycles in S_OUT -> instruction/pc_plus_4/valid_out held unchanged for 5 cycles; imem_req=0 during hold.
- redirect_valid with redirect_pc=32'h1000 during S_WAIT, then rvalid with rdata=32'hDEAD_BEEF -> no valid_out; next imem_addr=32'h1000; perf_discarded=1 when FETCH_PERF_EN is defined.
- redirect_valid & imem_ready in the same S_REQ cycle (pc=32'h8, redirect_pc=32'h20) -> response for 32'h8 dropped; next request addr=32'h20.
- pc=32'hFFFF_FFFC fetch -> pc_plus_4=32'h0, next imem_addr=32'h0. Separately, rst_n low mid-S_WAIT -> outputs zero immediately, first request after release is RESET_PC.
